// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and the per-digit dabble correction
// for the BCD-to-binary reverse double-dabble converter.
package bcd_pkg;

    localparam int DEFAULT_DIGITS = 3;
    localparam int DEFAULT_BIN_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Undo the doubling a BCD digit received on the forward dabble.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] nibble);
        return (nibble >= 4'd8) ? (nibble - 4'd3) : nibble;
    endfunction

endpackage

// File: rtl/bcd2binary_reverse_dabble_if.sv
// Request/result handshake bundle for bcd2binary_reverse_dabble.
// master = requester/consumer side, slave = converter side.
interface bcd2binary_reverse_dabble_if #(
    parameter int DIGITS = bcd_pkg::DEFAULT_DIGITS,
    parameter int BIN_W  = bcd_pkg::DEFAULT_BIN_W
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      out_binary;
    logic                  out_err;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_binary, out_err
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_binary, out_err
    );
endinterface

// File: rtl/bcd_digit_adjust.sv
// One BCD digit of the reverse-dabble step: values of 8 or more lose 3.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);
    assign o_nibble = dabble_adjust(i_nibble);
endmodule

// File: rtl/bcd2binary_reverse_dabble.sv
// Sequential BCD-to-binary converter using reverse double dabble, one bit per cycle.
// Optional macro BCD2BIN_ERR_CHECK_EN: reject requests containing nibbles > 9.
module bcd2binary_reverse_dabble
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS,
    parameter int BIN_W  = DEFAULT_BIN_W
) (
    input  logic                              clk,
    input  logic                              reset,
    bcd2binary_reverse_dabble_if.slave        bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SCR_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SCR_W-1:0]   r_scratch;
    logic [SCR_W-1:0]   w_scratch_nxt;
    logic [SCR_W-1:0]   w_shifted;
    logic [SCR_W-1:0]   w_adjusted;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_bad;

    assign w_shifted                = r_scratch >> 1;
    assign w_adjusted[BIN_W-1:0]    = w_shifted[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_nibble (w_shifted [BIN_W + 4*g +: 4]),
            .o_nibble (w_adjusted[BIN_W + 4*g +: 4])
        );
    end

`ifdef BCD2BIN_ERR_CHECK_EN
    // Flag any request nibble outside 0..9.
    always_comb begin
        w_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            w_bad = w_bad | (bus.in_bcd[4*d +: 4] > 4'd9);
        end
    end
`else
    assign w_bad = 1'b0;
`endif

    // Next-state, scratch and counter update. The counter runs to BIN_W so the
    // last SHIFT cycle only hands over to DONE, giving a BIN_W+1 edge latency.
    always_comb begin
        w_state_nxt   = r_state;
        w_scratch_nxt = r_scratch;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = r_err;
        case (r_state)
            IDLE: begin
                if (bus.in_valid && w_bad) begin
                    w_state_nxt   = DONE;
                    w_scratch_nxt = {SCR_W{1'b0}};
                    w_cnt_nxt     = {CNT_W{1'b0}};
                    w_err_nxt     = 1'b1;
                end else if (bus.in_valid) begin
                    w_state_nxt   = SHIFT;
                    w_scratch_nxt = {bus.in_bcd, {BIN_W{1'b0}}};
                    w_cnt_nxt     = {CNT_W{1'b0}};
                    w_err_nxt     = 1'b0;
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            SHIFT: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt   = DONE;
                end else begin
                    w_scratch_nxt = w_adjusted;
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake flags registered from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_scratch   <= {SCR_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_scratch   <= w_scratch_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_binary = r_scratch[BIN_W-1:0];
    assign bus.out_err    = r_err;

endmodule

// File: tb/tb_bcd2binary_reverse_dabble.sv
// Directed bench for bcd2binary_reverse_dabble with a queue scoreboard
// fed at each accepted request and drained at each delivered result.
module tb_bcd2binary_reverse_dabble;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int LAT    = BIN_W + 1;

    typedef struct {
        int bin;
        int err;
        int lat;
        int acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    int   first_seen = 0;
    logic prev_valid = 1'b0;
    exp_t sb[$];

    bcd2binary_reverse_dabble_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd2binary_reverse_dabble #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [4*DIGITS-1:0] b, input int acc);
        exp_t e;
        int   v   = 0;
        bit   bad = 1'b0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            v   = v * 10 + int'(b[4*d +: 4]);
            bad = bad | (b[4*d +: 4] > 4'd9);
        end
        e.bin = v;
        e.err = 0;
        e.lat = LAT;
        e.acc = acc;
`ifdef BCD2BIN_ERR_CHECK_EN
        if (bad) begin
            e.bin = 0;
            e.err = 1;
            e.lat = 0;
        end
`endif
        return e;
    endfunction

    // Scoreboard monitor: compare on output handshakes, push on input handshakes.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            prev_valid = 1'b0;
        end else begin
            if (bus.out_valid && !prev_valid) first_seen = cyc;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(bus.out_binary), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("out_binary", 32'(bus.out_binary), 32'(e.bin));
                    check("out_err",    32'(bus.out_err),    32'(e.err));
                    check("latency",    32'(first_seen - e.acc), 32'(e.lat));
                end
                n_out++;
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_bcd, cyc + 1));
            prev_valid = bus.out_valid;
        end
    end

    task automatic send(input logic [4*DIGITS-1:0] b);
        bus.in_bcd   = b;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (bus.in_ready) begin
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_outputs(input int n);
        for (int k = 0; k < 200; k++) begin
            if (n_out >= n) break;
            @(posedge clk); #1;
        end
        check("wait_outputs", 32'(n_out >= n), 32'd1);
    endtask

    initial begin
        int n0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bcd    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",   32'(bus.in_ready),   32'd1);
        check("rst_out_valid",  32'(bus.out_valid),  32'd0);
        check("rst_out_binary", 32'(bus.out_binary), 32'd0);
        check("rst_out_err",    32'(bus.out_err),    32'd0);
        reset = 1'b0;

        // Basic conversions with the consumer always ready.
        send(12'h999);
        wait_outputs(1);
        send(12'h000);
        wait_outputs(2);
        send(12'h255);
        wait_outputs(3);

        // Back-pressure: result must hold in DONE while out_ready is low.
        bus.out_ready = 1'b0;
        send(12'h010);
        for (int k = 0; k < 50; k++) begin
            if (bus.out_valid) break;
            @(posedge clk); #1;
        end
        for (int k = 0; k < 5; k++) begin
            check("hold_valid",    32'(bus.out_valid),  32'd1);
            check("hold_binary",   32'(bus.out_binary), 32'd10);
            check("hold_in_ready", 32'(bus.in_ready),   32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready",  32'(bus.in_ready),  32'd1);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        wait_outputs(4);

        // Reset during the shift phase discards the conversion.
        send(12'h512);
        repeat (4) @(posedge clk);
        #1;
        check("shift_out_valid", 32'(bus.out_valid), 32'd0);
        check("shift_in_ready",  32'(bus.in_ready),  32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_in_ready",   32'(bus.in_ready),   32'd1);
        check("abort_out_valid",  32'(bus.out_valid),  32'd0);
        check("abort_out_binary", 32'(bus.out_binary), 32'd0);
        n0 = n_out;
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_result", 32'(n_out), 32'(n0));
        send(12'h512);
        wait_outputs(n0 + 1);

        // Continuous requests with a changing payload: only IDLE samples count.
        n0 = n_out;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            bus.in_bcd = {4'((k * 3) % 10), 4'((k * 7 + 1) % 10), 4'((k * 9 + 2) % 10)};
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0 && !bus.out_valid) break;
            @(posedge clk); #1;
        end
        check("stream_count_ok", 32'(n_out - n0 >= 4), 32'd1);

`ifdef BCD2BIN_ERR_CHECK_EN
        n0 = n_out;
        send(12'h1A3);
        check("err_out_valid",  32'(bus.out_valid),  32'd1);
        check("err_out_err",    32'(bus.out_err),    32'd1);
        check("err_out_binary", 32'(bus.out_binary), 32'd0);
        wait_outputs(n0 + 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd2binary_reverse_dabble.md
BCD2BINARY_REVERSE_DABBLE -- requirements
Module: bcd2binary_reverse_dabble

Interface
REQ-001 Parameter DIGITS, default 3, SHALL set the number of packed BCD input digits.
REQ-002 Parameter BIN_W, default 10, SHALL set the binary result width and the iteration count; BIN_W SHALL be at least ceil(log2(10^DIGITS)).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port in_valid, input, 1, SHALL indicate in_bcd holds a conversion request.
REQ-006 Port in_ready, output, 1, SHALL indicate the block can accept a request this cycle.
REQ-007 Port in_bcd, input, 4*DIGITS, SHALL carry packed BCD with the most significant digit in the top nibble.
REQ-008 Port out_valid, output, 1, SHALL indicate out_binary and out_err hold a result.
REQ-009 Port out_ready, input, 1, SHALL indicate the consumer accepts the result this cycle.
REQ-010 Port out_binary, output, BIN_W, SHALL carry the unsigned binary value of the accepted BCD.
REQ-011 Port out_err, output, 1, SHALL flag an input containing a nibble greater than 9.

Function
REQ-012 The block SHALL use FSM states IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge where in_valid and in_ready are both 1.
REQ-014 On transfer, the block SHALL load the scratch register as {in_bcd, BIN_W'b0}, clear the iteration counter and enter SHIFT.
REQ-015 Each SHIFT cycle SHALL shift the scratch right by 1, then subtract 3 from every BCD nibble of the upper 4*DIGITS bits whose post-shift value is >= 8, in a single combinational step.
REQ-016 After exactly BIN_W SHIFT cycles, the FSM SHALL enter DONE; out_valid SHALL first be 1 BIN_W+1 rising edges after the accepting edge.
REQ-017 out_binary SHALL equal the low BIN_W scratch bits, and out_binary, out_err and out_valid SHALL remain stable in DONE until out_ready is 1.
REQ-018 DONE with out_ready=1 SHALL return the FSM to IDLE on that edge; no new request is accepted on the same edge.
REQ-019 in_valid SHALL be ignored outside IDLE, and in_bcd changes during SHIFT or DONE SHALL not affect the result.
REQ-020 The iteration counter SHALL be $clog2(BIN_W+1) bits wide and SHALL not wrap during a conversion.
REQ-021 out_valid SHALL be 0 in IDLE and SHIFT.

Reset
REQ-022 When reset=1 at a rising edge, the block SHALL enter IDLE with in_ready=1, out_valid=0, out_binary=0, out_err=0, the counter at 0 and the scratch at 0, from any state.
REQ-023 A conversion interrupted by reset SHALL be discarded and no result produced.
REQ-024 Reset SHALL take priority over a simultaneous transfer or out_ready.

Configuration
REQ-025 With macro BCD2BIN_ERR_CHECK_EN defined, a request with any nibble > 9 SHALL bypass SHIFT, enter DONE on the next edge with out_err=1 and out_binary=0.
REQ-026 Without BCD2BIN_ERR_CHECK_EN, out_err SHALL be tied to 0, invalid nibbles SHALL be converted without checking, and the result for such inputs is undefined.

Structure
REQ-027 Package bcd_pkg SHALL hold the default DIGITS and BIN_W constants and the FSM state enum typedef.
REQ-028 Sub-module bcd_digit_adjust SHALL implement the per-nibble ">= 8 then subtract 3" correction; the top level SHALL instantiate one per digit.
REQ-029 The top level SHALL contain the FSM, counter, scratch register and handshake logic only.

Verification
REQ-030 The bench SHALL drive in_bcd=0x999 with out_ready held 1 and SHALL require out_binary=999 (0x3E7), out_err=0, out_valid rising 11 edges after accept.
REQ-031 The bench SHALL drive in_bcd=0x000 and SHALL require out_binary=0; it SHALL drive in_bcd=0x255 and SHALL require out_binary=255.
REQ-032 The bench SHALL drive in_bcd=0x010, hold out_ready=0 for 5 cycles in DONE, and SHALL require out_binary=10 stable with in_ready=0 throughout, then IDLE one edge after out_ready=1.
REQ-033 With BCD2BIN_ERR_CHECK_EN defined, the bench SHALL drive in_bcd=0x1A3 and SHALL require out_valid on the next edge with out_err=1 and out_binary=0.
REQ-034 The bench SHALL assert reset at SHIFT iteration 4 of 0x512, and SHALL then require IDLE, out_valid=0 and a subsequent 0x512 to yield 512.
REQ-035 The bench SHALL hold in_valid=1 continuously with changing in_bcd and SHALL require only values present in IDLE to be converted.
